// File: rtl/time_set_ctrl.sv
// time_set_ctrl -- interactive mm:ss editor for a seconds/minutes counter.
//
// A set press snapshots the live time into four edit registers. While
// editing, right/left move a one-hot cursor across the digits and inc/dec
// step the digit under it: tens wrap 0..5, ones wrap 0..9. A second set
// press commits the edit with a one-clock load strobe. Editing is abandoned
// without a strobe after TIMEOUT_S seconds with no button activity.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   set/right/left/inc/dec_btn      debounced button levels (active-high)
//   sec_tick                        one-clock pulse per second
//   cur_min_tens..cur_sec_ones      live time from the counter
//   load_min_tens..load_sec_ones    edit registers, presented to the counter
//   load_stb                        one-clock pulse: counter loads load_*
//   set_status                      high while snapshotting or editing
//   set_id                          one-hot cursor (bit3 = min tens)
//   set_num                         digit under the cursor, zero-extended
//   dbg_state                       FSM state (0 IDLE, 1 SNAP, 2 EDIT, 3 COMMIT)
//
// Timing: button levels are sampled into r_lvl on edge N. The event
// (r_lvl & ~r_prev) is then present for one cycle, so its effect shows on
// every registered output after edge N+1. A level held high produces only
// one event.
module time_set_ctrl #(
  parameter int unsigned TIMEOUT_S = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_btn,
  input  logic       right_btn,
  input  logic       left_btn,
  input  logic       inc_btn,
  input  logic       dec_btn,
  input  logic       sec_tick,
  input  logic [2:0] cur_min_tens,
  input  logic [3:0] cur_min_ones,
  input  logic [2:0] cur_sec_tens,
  input  logic [3:0] cur_sec_ones,
  output logic [2:0] load_min_tens,
  output logic [3:0] load_min_ones,
  output logic [2:0] load_sec_tens,
  output logic [3:0] load_sec_ones,
  output logic       load_stb,
  output logic       set_status,
  output logic [3:0] set_id,
  output logic [3:0] set_num,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SNAP   = 2'd1,
    S_EDIT   = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_S);

  // Event bit order: 4 set, 3 right, 2 left, 1 inc, 0 dec
  logic [4:0] r_lvl, r_prev, w_evt;
  state_t     r_state, w_next_state;
  logic [1:0] r_cursor, w_cursor;   // 0 = min tens .. 3 = sec ones
  logic [7:0] r_to, w_to;
  logic [2:0] w_mt, w_st;
  logic [3:0] w_mo, w_so;
  logic [3:0] w_digit;

  assign w_evt     = r_lvl & ~r_prev;
  assign dbg_state = r_state;

  function automatic logic [2:0] tens_step(input logic [2:0] v, input logic up);
    if (up) return (v >= 3'd5) ? 3'd0 : v + 3'd1;
    else    return (v == 3'd0) ? 3'd5 : v - 3'd1;
  endfunction

  function automatic logic [3:0] ones_step(input logic [3:0] v, input logic up);
    if (up) return (v >= 4'd9) ? 4'd0 : v + 4'd1;
    else    return (v == 4'd0) ? 4'd9 : v - 4'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lvl  <= '0;
      r_prev <= '0;
    end else begin
      r_lvl  <= {set_btn, right_btn, left_btn, inc_btn, dec_btn};
      r_prev <= r_lvl;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_cursor     = r_cursor;
    w_to         = r_to;
    w_mt         = load_min_tens;
    w_mo         = load_min_ones;
    w_st         = load_sec_tens;
    w_so         = load_sec_ones;
    case (r_state)
      S_IDLE: begin
        if (w_evt[4]) w_next_state = S_SNAP;
      end
      S_SNAP: begin
        w_mt         = cur_min_tens;
        w_mo         = cur_min_ones;
        w_st         = cur_sec_tens;
        w_so         = cur_sec_ones;
        w_cursor     = 2'd0;
        w_to         = 8'd0;
        w_next_state = S_EDIT;
      end
      S_EDIT: begin
        // Only the highest-priority event acts; the rest are dropped.
        if (w_evt[4]) begin
          w_next_state = S_COMMIT;
        end else if (w_evt[3]) begin
          w_cursor = r_cursor + 2'd1;
        end else if (w_evt[2]) begin
          w_cursor = r_cursor - 2'd1;
        end else if (w_evt[1] || w_evt[0]) begin
          case (r_cursor)
            2'd0:    w_mt = tens_step(load_min_tens, w_evt[1]);
            2'd1:    w_mo = ones_step(load_min_ones, w_evt[1]);
            2'd2:    w_st = tens_step(load_sec_tens, w_evt[1]);
            default: w_so = ones_step(load_sec_ones, w_evt[1]);
          endcase
        end
        // Any button activity restarts the inactivity timer and wins
        // over a timeout that would expire in the same cycle.
        if (|w_evt) begin
          w_to = 8'd0;
        end else begin
          if (sec_tick && (r_to < TO_LIM)) w_to = r_to + 8'd1;
          if (r_to >= TO_LIM) w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_digit = 4'd0;
    case (w_cursor)
      2'd0:    w_digit = {1'b0, w_mt};
      2'd1:    w_digit = w_mo;
      2'd2:    w_digit = {1'b0, w_st};
      default: w_digit = w_so;
    endcase
  end

  // Outputs are registered from next-state values so they track r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cursor      <= 2'd0;
      r_to          <= 8'd0;
      load_min_tens <= '0;
      load_min_ones <= '0;
      load_sec_tens <= '0;
      load_sec_ones <= '0;
      load_stb      <= 1'b0;
      set_status    <= 1'b0;
      set_id        <= '0;
      set_num       <= '0;
    end else begin
      r_state       <= w_next_state;
      r_cursor      <= w_cursor;
      r_to          <= w_to;
      load_min_tens <= w_mt;
      load_min_ones <= w_mo;
      load_sec_tens <= w_st;
      load_sec_ones <= w_so;
      load_stb      <= (w_next_state == S_COMMIT);
      set_status    <= (w_next_state == S_SNAP) || (w_next_state == S_EDIT);
      set_id        <= (w_next_state == S_EDIT) ? (4'b1000 >> w_cursor) : 4'b0000;
      set_num       <= (w_next_state == S_EDIT) ? w_digit : 4'd0;
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
module tb_time_set_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       set_btn = 1'b0, right_btn = 1'b0, left_btn = 1'b0;
  logic       inc_btn = 1'b0, dec_btn = 1'b0, sec_tick = 1'b0;
  logic [2:0] cur_mt = '0, cur_st = '0;
  logic [3:0] cur_mo = '0, cur_so = '0;
  logic [2:0] load_min_tens, load_sec_tens;
  logic [3:0] load_min_ones, load_sec_ones;
  logic       load_stb, set_status;
  logic [3:0] set_id, set_num;
  logic [1:0] dbg_state;

  time_set_ctrl #(.TIMEOUT_S(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .set_btn(set_btn), .right_btn(right_btn), .left_btn(left_btn),
    .inc_btn(inc_btn), .dec_btn(dec_btn), .sec_tick(sec_tick),
    .cur_min_tens(cur_mt), .cur_min_ones(cur_mo),
    .cur_sec_tens(cur_st), .cur_sec_ones(cur_so),
    .load_min_tens(load_min_tens), .load_min_ones(load_min_ones),
    .load_sec_tens(load_sec_tens), .load_sec_ones(load_sec_ones),
    .load_stb(load_stb), .set_status(set_status),
    .set_id(set_id), .set_num(set_num), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [25:0] exp_q[$];
  int stb_cnt = 0;

  always @(negedge clk) if (load_stb === 1'b1) stb_cnt++;

  // Reference model of the edit registers and cursor
  int m_mt = 0, m_mo = 0, m_st = 0, m_so = 0, m_cur = 0;
  bit m_edit = 1'b0;

  function automatic logic [25:0] obs();
    return {dbg_state, set_status, set_id, set_num, load_min_tens,
            load_min_ones, load_sec_tens, load_sec_ones, load_stb};
  endfunction

  // st: 0 idle, 2 edit, 3 commit
  function automatic logic [25:0] mk(input logic [1:0] st, input bit stb);
    logic [3:0] one, id, num;
    one = 4'b1000;
    id  = 4'd0;
    num = 4'd0;
    if (st == 2'd2) begin
      id = one >> m_cur;
      case (m_cur)
        0:       num = 4'(m_mt);
        1:       num = 4'(m_mo);
        2:       num = 4'(m_st);
        default: num = 4'(m_so);
      endcase
    end
    return {st, (st == 2'd2), id, num, 3'(m_mt), 4'(m_mo), 3'(m_st), 4'(m_so), stb};
  endfunction

  task automatic step_digit(input int dir);
    case (m_cur)
      0:       m_mt = (m_mt + dir + 6) % 6;
      1:       m_mo = (m_mo + dir + 10) % 10;
      2:       m_st = (m_st + dir + 6) % 6;
      default: m_so = (m_so + dir + 10) % 10;
    endcase
  endtask

  task automatic check_pop(input string tag);
    logic [25:0] e, o;
    e = exp_q.pop_front();
    o = obs();
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic check_int(input string tag, input int o, input int e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle press of any button combination; model and expectation are
  // updated when the stimulus is driven, compared once the action shows.
  task automatic press(input logic s, r, l, i, d, input string tag);
    bit enter;
    enter = 1'b0;
    if (!m_edit) begin
      if (s) begin
        enter = 1'b1;
        m_mt = cur_mt; m_mo = cur_mo; m_st = cur_st; m_so = cur_so;
        m_cur = 0; m_edit = 1'b1;
        exp_q.push_back(mk(2'd2, 1'b0));
      end else begin
        exp_q.push_back(mk(2'd0, 1'b0));
      end
    end else if (s) begin
      m_edit = 1'b0;
      exp_q.push_back(mk(2'd3, 1'b1));
    end else begin
      if (r)      m_cur = (m_cur + 1) % 4;
      else if (l) m_cur = (m_cur + 3) % 4;
      else if (i) step_digit(1);
      else if (d) step_digit(-1);
      exp_q.push_back(mk(2'd2, 1'b0));
    end
    set_btn = s; right_btn = r; left_btn = l; inc_btn = i; dec_btn = d;
    tick(1);
    set_btn = 0; right_btn = 0; left_btn = 0; inc_btn = 0; dec_btn = 0;
    tick(1);
    if (enter) tick(1);
    check_pop(tag);
  endtask

  task automatic sec_pulse();
    sec_tick = 1'b1;
    tick(1);
    sec_tick = 1'b0;
    tick(1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int stb0;

    // reset state
    #3;
    exp_q.push_back(mk(2'd0, 1'b0));
    check_pop("reset_values");
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // 12:34 snapshot
    cur_mt = 3'd1; cur_mo = 4'd2; cur_st = 3'd3; cur_so = 4'd4;
    press(0, 0, 0, 1, 0, "idle_inc_ignored");
    press(1, 0, 0, 0, 0, "enter_edit_1234");

    // min tens: up to 5, wrap to 0, dec wraps back to 5
    for (int k = 0; k < 4; k++) press(0, 0, 0, 1, 0, "inc_min_tens");
    press(0, 0, 0, 1, 0, "inc_tens_wrap_5_to_0");
    press(0, 0, 0, 0, 1, "dec_tens_wrap_0_to_5");

    // min ones 2 -> 9 through the 0 -> 9 wrap
    press(0, 1, 0, 0, 0, "right_to_min_ones");
    for (int k = 0; k < 3; k++) press(0, 0, 0, 0, 1, "dec_min_ones");

    // sec tens 3 -> 5
    press(0, 1, 0, 0, 0, "right_to_sec_tens");
    for (int k = 0; k < 2; k++) press(0, 0, 0, 1, 0, "inc_sec_tens");

    // sec ones 4 -> 0 -> 9
    press(0, 1, 0, 0, 0, "right_to_sec_ones");
    for (int k = 0; k < 4; k++) press(0, 0, 0, 0, 1, "dec_sec_ones");
    press(0, 0, 0, 0, 1, "dec_ones_wrap_0_to_9");

    // cursor movement and priority
    press(0, 1, 0, 1, 0, "right_and_inc_moves_only");
    for (int k = 0; k < 4; k++) press(0, 1, 0, 0, 0, "four_rights");
    press(0, 0, 1, 0, 0, "left_wrap_to_sec_ones");
    press(0, 1, 0, 0, 0, "right_wrap_to_min_tens");

    // commit 59:59 with simultaneous inc
    stb0 = stb_cnt;
    press(1, 0, 0, 1, 0, "commit_5959");
    exp_q.push_back(mk(2'd0, 1'b0));
    tick(1);
    check_pop("after_commit_idle");
    tick(3);
    check_int("stb_pulse_count", stb_cnt - stb0, 1);

    // timeout with restart by inc
    cur_mt = 3'd0; cur_mo = 4'd4; cur_st = 3'd5; cur_so = 4'd6;
    press(1, 0, 0, 0, 0, "enter_edit_0456");
    stb0 = stb_cnt;
    sec_pulse();
    sec_pulse();
    press(0, 0, 0, 1, 0, "inc_restarts_timeout");
    sec_pulse();
    sec_pulse();
    exp_q.push_back(mk(2'd2, 1'b0));
    check_pop("two_ticks_still_edit");
    sec_pulse();
    m_edit = 1'b0;
    exp_q.push_back(mk(2'd0, 1'b0));
    check_pop("timeout_to_idle");
    check_int("timeout_no_stb", stb_cnt - stb0, 0);

    // held inc yields a single step
    press(1, 0, 0, 0, 0, "enter_edit_held");
    step_digit(1);
    exp_q.push_back(mk(2'd2, 1'b0));
    inc_btn = 1'b1;
    tick(100);
    inc_btn = 1'b0;
    tick(2);
    check_pop("held_inc_single_step");

    // async reset mid-edit
    press(0, 0, 0, 1, 0, "inc_before_reset");
    stb0 = stb_cnt;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    m_mt = 0; m_mo = 0; m_st = 0; m_so = 0; m_cur = 0; m_edit = 1'b0;
    exp_q.push_back(mk(2'd0, 1'b0));
    check_pop("async_reset_mid_edit");
    check_int("reset_no_stb", stb_cnt - stb0, 0);

    // set held through reset release gives exactly one event
    set_btn = 1'b1;
    tick(2);
    rst_n = 1'b1;
    m_mt = cur_mt; m_mo = cur_mo; m_st = cur_st; m_so = cur_so;
    m_cur = 0; m_edit = 1'b1;
    exp_q.push_back(mk(2'd2, 1'b0));
    tick(3);
    check_pop("held_set_through_reset");
    exp_q.push_back(mk(2'd2, 1'b0));
    tick(5);
    set_btn = 1'b0;
    tick(2);
    check_pop("held_set_single_event");
    press(1, 0, 0, 0, 0, "final_commit");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter: TIMEOUT_S, default 30, number of sec_tick pulses without a button edge in EDIT before editing is aborted (range 1-255).
REQ-002 Port: clk  in  1  system clock, 100 MHz from PLL.
REQ-003 Port: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 Port: set_btn, right_btn, left_btn, inc_btn, dec_btn  in  1 each  debounced button levels, active-high, synchronous to clk.
REQ-005 Port: sec_tick  in  1  one-clk pulse once per counted second.
REQ-006 Port: cur_min_tens  in  3, cur_min_ones  in  4, cur_sec_tens  in  3, cur_sec_ones  in  4  live time from counter.
REQ-007 Port: load_min_tens  out  3, load_min_ones  out  4, load_sec_tens  out  3, load_sec_ones  out  4  edited time (edit registers).
REQ-008 Port: load_stb  out  1  one-clk pulse; counter loads load_* on it.
REQ-009 Port: set_status  out  1  high while editing.
REQ-010 Port: set_id  out  4  one-hot cursor; bit3=min tens, bit2=min ones, bit1=sec tens, bit0=sec ones.
REQ-011 Port: set_num  out  4  value of digit under cursor, zero-extended.

Function
REQ-012 Each button SHALL be edge-detected with a registered previous level; event = level & ~prev; only events act, held levels are ignored.
REQ-013 All outputs SHALL be registered; action for an event sampled at clock edge N SHALL be visible after edge N+1.
REQ-014 FSM states SHALL be IDLE, SNAP, EDIT, COMMIT.
REQ-015 IDLE: set event -> SNAP; all other events ignored.
REQ-016 SNAP (1 clk): edit registers <= cur_* values; cursor <= min tens; timeout counter <= 0; -> EDIT.
REQ-017 EDIT: set event -> COMMIT; timeout counter reaching TIMEOUT_S -> IDLE with no load_stb and edit registers unchanged.
REQ-018 EDIT, one action per clk, priority set > right > left > inc > dec; lower-priority simultaneous events SHALL be dropped.
REQ-019 Right: cursor moves toward sec ones; sec ones wraps to min tens. Left: reverse; min tens wraps to sec ones.
REQ-020 Inc: tens digits 0..5, 5 -> 0; ones digits 0..9, 9 -> 0. Dec: tens 0 -> 5; ones 0 -> 9. Only cursor digit changes.
REQ-021 Timeout counter SHALL increment on sec_tick in EDIT, clear on any button event in EDIT, and saturate at TIMEOUT_S.
REQ-022 COMMIT (1 clk): load_stb = 1 with load_* holding edited values; -> IDLE.
REQ-023 set_status SHALL be 1 in SNAP and EDIT, else 0.
REQ-024 set_id SHALL be the one-hot cursor in EDIT, 4'b0000 otherwise; set_num SHALL be the cursor digit in EDIT, 0 otherwise.
REQ-025 load_* SHALL hold their values in IDLE and change only in SNAP and EDIT.

Reset
REQ-026 On rst_n low, state SHALL be IDLE immediately, regardless of clk.
REQ-027 Reset values SHALL be: load_* = 0, load_stb = 0, set_status = 0, set_id = 0, set_num = 0, cursor = min tens, timeout counter = 0, previous-level registers = 0.
REQ-028 Reset mid-EDIT SHALL discard edits with no load_stb.
REQ-029 A button held high through reset release SHALL produce one event on the first clk after release.

Verification
REQ-030 Time 12:34, set pulse -> set_status=1, set_id=4'b1000, set_num=1; load_*=1,2,3,4.
REQ-031 In EDIT with cursor min tens=5, inc -> 0; with cursor sec ones=0, dec -> 9; four rights from min tens -> back to min tens (4'b1000).
REQ-032 Edit to 59:59, then set -> exactly one load_stb pulse with load_*=5,9,5,9; next clk set_status=0, set_id=0.
REQ-033 TIMEOUT_S=3, enter EDIT, send 3 sec_tick with no buttons -> IDLE, no load_stb, set_status=0; one inc before the 3rd tick restarts the count.
REQ-034 set and inc rise in the same clk in EDIT -> COMMIT only, digit unchanged; right and inc together -> cursor moves, digit unchanged.
REQ-035 Inc held high 100 clks -> single increment; rst_n low mid-EDIT -> all outputs at reset values asynchronously, no load_stb.
